// File: rtl/multi_timer_if.sv
// ----------------------------------------------------------------------------
// multi_timer_if
// Bus bundle for the multi_timer peripheral (AS_L/WE_L strobe bus).
//
//   AS_L     : address strobe, active low
//   WE_L     : write enable, active low (0 = write, 1 = read while AS_L = 0)
//   addr     : {channel index[CH_W-1:0], reg sel[1:0]}
//   data_in  : write data
//   data_out : registered read data
//
// master modport: the CPU side; slave modport: the timer peripheral.
// ----------------------------------------------------------------------------
interface multi_timer_if #(
    parameter int CH_W = 2
);
    logic            AS_L;
    logic            WE_L;
    logic [CH_W+1:0] addr;
    logic [31:0]     data_in;
    logic [31:0]     data_out;

    modport master (
        output AS_L,
        output WE_L,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  AS_L,
        input  WE_L,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/multi_timer.sv
// ----------------------------------------------------------------------------
// multi_timer
// NUM_CH independent countdown timers behind a simple AS_L/WE_L register bus.
// Each channel has a reload register, an 8-bit prescaler, one-shot or
// periodic mode, sticky PEND/OVR status and an interrupt enable.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : multi_timer_if.slave (AS_L, WE_L, addr, data_in, data_out)
//   irq_out  : per-channel level interrupt, registered PEND & IE
//   irq_any  : registered OR of all (PEND & IE), aligned with irq_out
//
// Register map per channel (addr = {channel, sel}):
//   0 CTRL   : [0] EN, [1] IE, [2] AUTO, [15:8] PRE; writing reloads COUNT
//   1 RELOAD : countdown start value (WIDTH bits)
//   2 COUNT  : current count, read-only
//   3 STATUS : [0] PEND, [1] OVR, write-1-to-clear
// ----------------------------------------------------------------------------
module multi_timer #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    multi_timer_if.slave      bus,
    output logic [NUM_CH-1:0] irq_out,
    output logic              irq_any
);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RELOAD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    // Field order matches the low CTRL bits so {PRE, data_in[2:0]} packs directly.
    typedef struct packed {
        logic [7:0] pre;
        logic       auto_rl;
        logic       ie;
        logic       en;
    } ctrl_t;

    ctrl_t             ctrl_q    [NUM_CH];
    logic [WIDTH-1:0]  reload_q  [NUM_CH];
    logic [WIDTH-1:0]  count_q   [NUM_CH];
    logic [7:0]        pre_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] ovr_q;

    logic              bus_wr;
    logic              bus_rd;
    logic [CH_W-1:0]   ch_sel;
    reg_sel_e          reg_sel;

    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] reload_wr;
    logic [NUM_CH-1:0] status_wr;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] ie_vec;
    logic [NUM_CH-1:0] pend_clr;
    logic [NUM_CH-1:0] ovr_clr;
    logic [31:0]       rd_data;

    assign bus_wr  = !bus.AS_L && !bus.WE_L;
    assign bus_rd  = !bus.AS_L &&  bus.WE_L;
    assign ch_sel  = bus.addr[CH_W+1:2];
    assign reg_sel = reg_sel_e'(bus.addr[1:0]);

    // Per-channel decode. Channel indices >= NUM_CH never match, so writes to
    // them fall on the floor and reads of them return zero.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ctrl_wr   = '0;
        reload_wr = '0;
        status_wr = '0;
        tick      = '0;
        expire    = '0;
        ie_vec    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ctrl_wr[i]   = bus_wr && (ch_sel == CH_W'(i)) && (reg_sel == REG_CTRL);
            reload_wr[i] = bus_wr && (ch_sel == CH_W'(i)) && (reg_sel == REG_RELOAD);
            status_wr[i] = bus_wr && (ch_sel == CH_W'(i)) && (reg_sel == REG_STATUS);
            tick[i]      = ctrl_q[i].en && (pre_cnt_q[i] == ctrl_q[i].pre);
            // A CTRL write on the same cycle discards the tick, and with it any expiry.
            expire[i]    = tick[i] && (count_q[i] == '0) && !ctrl_wr[i];
            ie_vec[i]    = ctrl_q[i].ie;
        end
    end

    assign pend_clr = status_wr & {NUM_CH{bus.data_in[0]}};
    assign ovr_clr  = status_wr & {NUM_CH{bus.data_in[1]}};

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values (e.g. the auto-reload below sees the old RELOAD
    // even when RELOAD is written on the same edge).
    // NOTE: the per-channel register arrays are software-visible and must read
    // zero after reset, so they are reset like ordinary flops rather than
    // being left to a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctrl_q[i]    <= '0;
                reload_q[i]  <= '0;
                count_q[i]   <= '0;
                pre_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctrl_wr[i]) begin
                    ctrl_q[i]    <= {bus.data_in[15:8], bus.data_in[2:0]};
                    count_q[i]   <= reload_q[i];
                    pre_cnt_q[i] <= '0;
                end else if (ctrl_q[i].en) begin
                    pre_cnt_q[i] <= tick[i] ? 8'd0 : pre_cnt_q[i] + 8'd1;
                    if (tick[i]) begin
                        if (count_q[i] != '0) begin
                            count_q[i] <= count_q[i] - WIDTH'(1);
                        end else if (ctrl_q[i].auto_rl) begin
                            count_q[i] <= reload_q[i];
                        end else begin
                            // One-shot: COUNT holds at 0 and the channel stops itself.
                            ctrl_q[i].en <= 1'b0;
                        end
                    end
                end
                if (reload_wr[i]) begin
                    reload_q[i] <= bus.data_in[WIDTH-1:0];
                end
            end
        end
    end

    // Sticky status: a set on the same cycle as a W1C wins; OVR looks at the
    // PEND value from before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | expire;
            ovr_q  <= (ovr_q  & ~ovr_clr)  | (expire & pend_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_out <= '0;
            irq_any <= 1'b0;
        end else begin
            irq_out <= pend_q & ie_vec;
            irq_any <= |(pend_q & ie_vec);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rd_data = {16'd0, ctrl_q[i].pre, 5'd0,
                                           ctrl_q[i].auto_rl, ctrl_q[i].ie, ctrl_q[i].en};
                    REG_RELOAD: rd_data = 32'(reload_q[i]);
                    REG_COUNT:  rd_data = 32'(count_q[i]);
                    REG_STATUS: rd_data = {30'd0, ovr_q[i], pend_q[i]};
                    default:    rd_data = '0;
                endcase
            end
        end
    end

    // data_out only changes on a read and otherwise holds the last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_out <= '0;
        end else if (bus_rd) begin
            bus.data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// ----------------------------------------------------------------------------
// tb_multi_timer
// Self-checking bench for multi_timer. Two instances: the default 4-channel
// build and a 3-channel build for the unmapped-channel case. Read results are
// predicted when the read is issued (pushed to a queue) and popped when the
// registered data_out appears one cycle later.
// ----------------------------------------------------------------------------
module tb_multi_timer;

    localparam int R_CTRL   = 0;
    localparam int R_RELOAD = 1;
    localparam int R_COUNT  = 2;
    localparam int R_STATUS = 3;

    logic       clk;
    logic       reset_n;
    logic [3:0] irq_out4;
    logic       irq_any4;
    logic [2:0] irq_out3;
    logic       irq_any3;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] sb [$];

    multi_timer_if #(.CH_W(2)) bus4 ();
    multi_timer_if #(.CH_W(2)) bus3 ();

    multi_timer #(.NUM_CH(4), .WIDTH(32), .CH_W(2)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4),
        .irq_out (irq_out4),
        .irq_any (irq_any4)
    );

    multi_timer #(.NUM_CH(3), .WIDTH(32), .CH_W(2)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3),
        .irq_out (irq_out3),
        .irq_any (irq_any3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus4.AS_L = 1'b1; bus4.WE_L = 1'b1;
        bus3.AS_L = 1'b1; bus3.WE_L = 1'b1;
    endtask

    task automatic set_wr(input bit on3, input int ch, input int sel, input logic [31:0] d);
        if (on3) begin
            bus3.AS_L = 1'b0; bus3.WE_L = 1'b0; bus3.addr = 4'(ch * 4 + sel); bus3.data_in = d;
        end else begin
            bus4.AS_L = 1'b0; bus4.WE_L = 1'b0; bus4.addr = 4'(ch * 4 + sel); bus4.data_in = d;
        end
    endtask

    task automatic bus_write(input bit on3, input int ch, input int sel, input logic [31:0] d);
        set_wr(on3, ch, sel, d);
        cyc();
        set_idle();
    endtask

    // Drive a read strobe and record what it must return.
    task automatic issue_read(input bit on3, input int ch, input int sel, input logic [31:0] want);
        if (on3) begin
            bus3.AS_L = 1'b0; bus3.WE_L = 1'b1; bus3.addr = 4'(ch * 4 + sel);
        end else begin
            bus4.AS_L = 1'b0; bus4.WE_L = 1'b1; bus4.addr = 4'(ch * 4 + sel);
        end
        sb.push_back(want);
    endtask

    // Advance to the edge that registers the read and pop its prediction.
    task automatic read_pop(input bit on3, output logic [31:0] got, output logic [31:0] exp);
        cyc();
        got = on3 ? bus3.data_out : bus4.data_out;
        exp = sb.pop_front();
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        set_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (irq_out4 !== 4'h0) begin n_mis++; $display("FAIL reset_irq_out: got %b want 0000", irq_out4); end
        n_cmp++; if (irq_any4 !== 1'b0) begin n_mis++; $display("FAIL reset_irq_any: got %b want 0", irq_any4); end
        n_cmp++; if (bus4.data_out !== 32'h0) begin n_mis++; $display("FAIL reset_data_out: got %h want 0", bus4.data_out); end
        @(negedge clk); reset_n = 1'b1;
        cyc();
        // ch1 one-shot with RELOAD=0 raises its IRQ two edges after the write.
        bus_write(0, 1, R_CTRL, 32'h3);
        cyc(); cyc();
        n_cmp++; if (irq_out4[1] !== 1'b1) begin n_mis++; $display("FAIL pre_reset_irq: got %b want 1", irq_out4[1]); end
        bus_write(0, 0, R_RELOAD, 32'd100);
        bus_write(0, 0, R_CTRL, 32'h1);
        repeat (5) cyc();
        issue_read(0, 0, R_RELOAD, 32'd100); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL pre_reset_read: got %h want %h", got, exp); end
        // Assert reset between edges: outputs must drop without a clock.
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (irq_out4 !== 4'h0) begin n_mis++; $display("FAIL async_irq_out: got %b want 0000", irq_out4); end
        n_cmp++; if (irq_any4 !== 1'b0) begin n_mis++; $display("FAIL async_irq_any: got %b want 0", irq_any4); end
        n_cmp++; if (bus4.data_out !== 32'h0) begin n_mis++; $display("FAIL async_data_out: got %h want 0", bus4.data_out); end
        @(negedge clk); reset_n = 1'b1;
        cyc();
        issue_read(0, 0, R_COUNT, 32'h0);  read_pop(0, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL reset_count: got %h want %h", got, exp); end
        issue_read(0, 0, R_CTRL, 32'h0);   read_pop(0, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL reset_ctrl: got %h want %h", got, exp); end
        issue_read(0, 1, R_STATUS, 32'h0); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL reset_status: got %h want %h", got, exp); end
    endtask

    task automatic test_one_shot();
        logic [31:0] got, exp;
        bus_write(0, 0, R_RELOAD, 32'd5);
        bus_write(0, 0, R_CTRL, 32'h003);
        // (RELOAD+1)*(PRE+1) = 6 cycles to PEND, IRQ one cycle later.
        for (int k = 1; k <= 7; k++) begin
            cyc();
            n_cmp++;
            if (irq_out4[0] !== (k == 7)) begin
                n_mis++; $display("FAIL oneshot_irq_c%0d: got %b want %b", k, irq_out4[0], (k == 7));
            end
        end
        issue_read(0, 0, R_COUNT, 32'h0);   read_pop(0, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL oneshot_count: got %h want %h", got, exp); end
        issue_read(0, 0, R_CTRL, 32'h002);  read_pop(0, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL oneshot_ctrl: got %h want %h", got, exp); end
        issue_read(0, 0, R_STATUS, 32'h1);  read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL oneshot_status: got %h want %h", got, exp); end
        bus_write(0, 0, R_STATUS, 32'h1);
        cyc();
        n_cmp++; if (irq_out4[0] !== 1'b0) begin n_mis++; $display("FAIL oneshot_w1c_irq: got %b want 0", irq_out4[0]); end
        bus_write(0, 0, R_CTRL, 32'h0);
    endtask

    task automatic test_periodic();
        logic [31:0] got, exp;
        logic        want;
        bus_write(0, 1, R_RELOAD, 32'd3);
        bus_write(0, 1, R_CTRL, 32'h0107);
        // PEND every 8 cycles (edges 8, 16, 24); cleared two edges later.
        for (int n = 1; n <= 26; n++) begin
            if (n == 10 || n == 18 || n == 26) set_wr(0, 1, R_STATUS, 32'h1);
            else set_idle();
            cyc();
            want = (n >= 9) && ((n % 8) == 1 || (n % 8) == 2);
            n_cmp++;
            if (irq_out4[1] !== want) begin
                n_mis++; $display("FAIL periodic_irq_c%0d: got %b want %b", n, irq_out4[1], want);
            end
        end
        issue_read(0, 1, R_CTRL, 32'h0107); read_pop(0, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL periodic_ctrl: got %h want %h", got, exp); end
        issue_read(0, 1, R_STATUS, 32'h0);  read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL periodic_no_ovr: got %h want %h", got, exp); end
        bus_write(0, 1, R_CTRL, 32'h0);
        bus_write(0, 1, R_STATUS, 32'h3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        int          sels [4];
        logic [31:0] wants [4];
        sels  = '{R_STATUS, R_CTRL, R_RELOAD, R_COUNT};
        wants = '{32'h0, 32'h0000_FF06, 32'h5, 32'hDEAD_BEEF};
        bus_write(0, 1, R_RELOAD, 32'hDEAD_BEEF);
        bus_write(0, 1, R_CTRL, 32'hFFFF_FF06);  // EN=0, IE, AUTO, PRE=FF
        bus_write(0, 1, R_COUNT, 32'h1234);      // read-only
        bus_write(0, 1, R_RELOAD, 32'h5);        // must not disturb COUNT
        for (int k = 0; k < 4; k++) begin
            issue_read(0, 1, sels[k], wants[k]);
            read_pop(0, got, exp);
            n_cmp++;
            if (got !== exp) begin n_mis++; $display("FAIL b2b_sel%0d: got %h want %h", sels[k], got, exp); end
        end
        set_idle();
        repeat (2) cyc();
        n_cmp++; if (bus4.data_out !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL data_out_hold: got %h want deadbeef", bus4.data_out); end
        bus_write(0, 1, R_CTRL, 32'h0);
    endtask

    task automatic test_overrun();
        logic [31:0] got, exp;
        bus_write(0, 2, R_RELOAD, 32'h0);
        bus_write(0, 2, R_CTRL, 32'h7);      // AUTO, IE, EN, PRE=0: expires every edge
        cyc();
        issue_read(0, 2, R_STATUS, 32'h1); read_pop(0, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL ovr_first: got %h want %h", got, exp); end
        issue_read(0, 2, R_STATUS, 32'h3); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL ovr_second: got %h want %h", got, exp); end
        n_cmp++; if (irq_out4[2] !== 1'b1 || irq_any4 !== 1'b1) begin
            n_mis++; $display("FAIL ovr_irq: got %b/%b want 1/1", irq_out4[2], irq_any4);
        end
        // Restart from clean status, then W1C exactly on the first expiry edge.
        bus_write(0, 2, R_CTRL, 32'h6);
        bus_write(0, 2, R_STATUS, 32'h3);
        bus_write(0, 2, R_CTRL, 32'h7);
        bus_write(0, 2, R_STATUS, 32'h3);
        issue_read(0, 2, R_STATUS, 32'h1); read_pop(0, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL set_wins: got %h want %h", got, exp); end
        issue_read(0, 2, R_STATUS, 32'h3); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL set_wins_next: got %h want %h", got, exp); end
        bus_write(0, 2, R_CTRL, 32'h0);
        bus_write(0, 2, R_STATUS, 32'h3);
    endtask

    task automatic test_collisions();
        logic [31:0] got, exp;
        // CTRL write on a tick edge: COUNT restarts at RELOAD, the tick is lost.
        bus_write(0, 0, R_RELOAD, 32'd3);
        bus_write(0, 0, R_CTRL, 32'h1);
        cyc(); cyc();
        bus_write(0, 0, R_CTRL, 32'h1);
        issue_read(0, 0, R_COUNT, 32'd3); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL ctrl_wins: got %h want %h", got, exp); end
        // RELOAD write on an auto-reload expiry edge: old value reloads first.
        bus_write(0, 0, R_RELOAD, 32'd2);
        bus_write(0, 0, R_CTRL, 32'h5);
        cyc(); cyc();
        bus_write(0, 0, R_RELOAD, 32'd7);
        issue_read(0, 0, R_COUNT, 32'd2); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL reload_old: got %h want %h", got, exp); end
        cyc(); cyc();
        issue_read(0, 0, R_COUNT, 32'd7); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL reload_new: got %h want %h", got, exp); end
        bus_write(0, 0, R_CTRL, 32'h0);
        bus_write(0, 0, R_STATUS, 32'h3);
    endtask

    task automatic test_multi();
        logic [31:0] got, exp;
        bus_write(0, 0, R_RELOAD, 32'd2);
        bus_write(0, 3, R_RELOAD, 32'd2);
        bus_write(0, 0, R_CTRL, 32'h3);
        bus_write(0, 3, R_CTRL, 32'h3);
        repeat (3) cyc();
        n_cmp++; if (irq_out4 !== 4'b0001 || irq_any4 !== 1'b1) begin
            n_mis++; $display("FAIL multi_ch0_only: got %b/%b want 0001/1", irq_out4, irq_any4);
        end
        cyc();
        n_cmp++; if (irq_out4 !== 4'b1001 || irq_any4 !== 1'b1) begin
            n_mis++; $display("FAIL multi_both: got %b/%b want 1001/1", irq_out4, irq_any4);
        end
        bus_write(0, 0, R_CTRL, 32'h0);      // IE off masks ch0, PEND kept
        cyc();
        n_cmp++; if (irq_out4 !== 4'b1000 || irq_any4 !== 1'b1) begin
            n_mis++; $display("FAIL multi_mask_ch0: got %b/%b want 1000/1", irq_out4, irq_any4);
        end
        issue_read(0, 0, R_STATUS, 32'h1); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL masked_pend: got %h want %h", got, exp); end
        bus_write(0, 3, R_STATUS, 32'h1);
        cyc();
        n_cmp++; if (irq_out4 !== 4'b0000 || irq_any4 !== 1'b0) begin
            n_mis++; $display("FAIL multi_cleared: got %b/%b want 0000/0", irq_out4, irq_any4);
        end
        issue_read(0, 3, R_STATUS, 32'h0); read_pop(0, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL ch3_status: got %h want %h", got, exp); end
        bus_write(0, 0, R_STATUS, 32'h3);
    endtask

    task automatic test_unmapped();
        logic [31:0] got, exp;
        bus_write(1, 2, R_RELOAD, 32'hAA);
        bus_write(1, 3, R_RELOAD, 32'h55);
        bus_write(1, 3, R_CTRL, 32'h3);
        repeat (3) cyc();
        n_cmp++; if (irq_out3 !== 3'b000 || irq_any3 !== 1'b0) begin
            n_mis++; $display("FAIL unmapped_irq: got %b/%b want 000/0", irq_out3, irq_any3);
        end
        issue_read(1, 2, R_RELOAD, 32'hAA); read_pop(1, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL ch2_reload: got %h want %h", got, exp); end
        issue_read(1, 3, R_RELOAD, 32'h0);  read_pop(1, got, exp);
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL ch3_reload: got %h want %h", got, exp); end
        issue_read(1, 3, R_CTRL, 32'h0);    read_pop(1, got, exp); set_idle();
        n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL ch3_ctrl: got %h want %h", got, exp); end
    endtask

    initial begin
        bus4.addr = '0; bus4.data_in = '0;
        bus3.addr = '0; bus3.data_in = '0;
        test_reset();
        test_one_shot();
        test_periodic();
        test_back_to_back();
        test_overrun();
        test_collisions();
        test_multi();
        test_unmapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
